// File: rtl/proc_step_ctrl.sv
`default_nettype none
// ============================================================================
// proc_step_ctrl : run / single-step / auto-repeat clock-enable controller
// Revision: 1.0
// ============================================================================
module proc_step_ctrl #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int RUN_DIV         = 50,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        key_step_n,
    input  logic        sw_step,
    output logic        step_en,
    output logic        running,
    output logic        key_level,
    output logic [15:0] step_count
);
    localparam int DB_W     = (DEBOUNCE_CYCLES > 0) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
    localparam int DIV_W    = (RUN_DIV > 1) ? $clog2(RUN_DIV) : 1;
    localparam int HOLD_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int HOLD_W   = $clog2(HOLD_MAX + 2);

    localparam logic [DB_W-1:0]   DB_LAST     = DB_W'(DEBOUNCE_CYCLES);
    localparam logic [DIV_W-1:0]  DIV_LAST    = DIV_W'(RUN_DIV - 1);
    localparam logic [HOLD_W-1:0] DELAY_LAST  = HOLD_W'(REPEAT_DELAY - 1);
    localparam logic [HOLD_W-1:0] PERIOD_LAST = HOLD_W'(REPEAT_PERIOD - 1);
    // bit 1 = switch (reset 1), bit 0 = key pressed level (reset released)
    localparam logic [1:0]        DB_RESET    = 2'b10;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_IDLE   = 2'd1,
        ST_HELD   = 2'd2,
        ST_REPEAT = 2'd3
    } state_t;

    logic [1:0] key_sync;
    logic [1:0] sw_sync;
    logic [1:0] db_in;
    logic [1:0] db_out;
    logic       sw_db;
    logic       key_prev;
    logic       press;

    state_t             state;
    state_t             state_nxt;
    logic [DIV_W-1:0]   div_cnt;
    logic [DIV_W-1:0]   div_nxt;
    logic [HOLD_W-1:0]  hold_cnt;
    logic [HOLD_W-1:0]  hold_nxt;
    logic               step_nxt;

    always_ff @(posedge clk) begin
        if (reset) begin
            key_sync <= 2'b11;
            sw_sync  <= 2'b11;
        end else begin
            key_sync <= {key_sync[0], key_step_n};
            sw_sync  <= {sw_sync[0], sw_step};
        end
    end

    assign db_in = {sw_sync[1], ~key_sync[1]};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_db
            logic [DB_W-1:0] cnt;
            logic            stable;
            always_ff @(posedge clk) begin
                if (reset) begin
                    cnt    <= '0;
                    stable <= DB_RESET[gi];
                end else if (db_in[gi] == stable) begin
                    cnt <= '0;
                end else if (cnt == DB_LAST) begin
                    stable <= db_in[gi];
                    cnt    <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
            assign db_out[gi] = stable;
        end
    endgenerate

    assign key_level = db_out[0];
    assign sw_db     = db_out[1];
    assign press     = key_level & ~key_prev;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            div_cnt    <= '0;
            hold_cnt   <= '0;
            key_prev   <= 1'b0;
            step_en    <= 1'b0;
            running    <= 1'b0;
            step_count <= '0;
        end else begin
            state      <= state_nxt;
            div_cnt    <= div_nxt;
            hold_cnt   <= hold_nxt;
            key_prev   <= key_level;
            step_en    <= step_nxt;
            running    <= (state_nxt == ST_RUN);
            step_count <= step_count + {15'd0, step_en};
        end
    end

    // Mode changes are tested first so a coincident press or wrap is dropped;
    // the !step_en guards keep pulses apart for tiny delay/period settings.
    always_comb begin
        state_nxt = state;
        div_nxt   = div_cnt;
        hold_nxt  = hold_cnt;
        step_nxt  = 1'b0;
        case (state)
            ST_RUN: begin
                if (sw_db) begin
                    state_nxt = ST_IDLE;
                    div_nxt   = '0;
                    hold_nxt  = '0;
                end else if (div_cnt == DIV_LAST) begin
                    div_nxt  = '0;
                    step_nxt = 1'b1;
                end else begin
                    div_nxt = div_cnt + 1'b1;
                end
            end
            ST_IDLE: begin
                if (!sw_db) begin
                    state_nxt = ST_RUN;
                    div_nxt   = '0;
                    hold_nxt  = '0;
                end else if (press) begin
                    state_nxt = ST_HELD;
                    hold_nxt  = '0;
                    step_nxt  = 1'b1;
                end
            end
            ST_HELD: begin
                if (!sw_db) begin
                    state_nxt = ST_RUN;
                    div_nxt   = '0;
                    hold_nxt  = '0;
                end else if (!key_level) begin
                    state_nxt = ST_IDLE;
                    hold_nxt  = '0;
                end else if ((hold_cnt >= DELAY_LAST) && !step_en) begin
                    state_nxt = ST_REPEAT;
                    hold_nxt  = '0;
                    step_nxt  = 1'b1;
                end else begin
                    hold_nxt = hold_cnt + 1'b1;
                end
            end
            ST_REPEAT: begin
                if (!sw_db) begin
                    state_nxt = ST_RUN;
                    div_nxt   = '0;
                    hold_nxt  = '0;
                end else if (!key_level) begin
                    state_nxt = ST_IDLE;
                    hold_nxt  = '0;
                end else if ((hold_cnt >= PERIOD_LAST) && !step_en) begin
                    hold_nxt = '0;
                    step_nxt = 1'b1;
                end else begin
                    hold_nxt = hold_cnt + 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end
endmodule
`default_nettype wire
